uart_rx_fifo: RTL and testbench

Receive buffer that sits directly downstream of the UART receiver. It captures each one-cycle rx_valid/rx_data byte strobe into a power-of-two FIFO and presents the oldest byte to the CPU register interface. The CPU drains it with a read strobe. The block flags overrun when a byte arrives while full. It raises an interrupt on a fill-level threshold or on a character timeout.

---
 rtl/uart_rx_fifo.sv | 95 +++++++++
 tb/tb_uart_rx_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the CPU register port.
// First-word-fall-through head, sticky overrun, and level/timeout interrupt.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  rd_strobe,
    output logic [7:0]            rd_data,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    input  logic                  flush,
    output logic                  overrun,
    input  logic                  overrun_clr,
    input  logic [DEPTH_LOG2:0]   irq_threshold,
    input  logic [15:0]           timeout_cycles,
    output logic                  irq
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [15:0]           idle_q, idle_d;
    logic                  overrun_q, overrun_d;
    logic                  empty, full, push, pop, drop;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FULL_CNT);
        pop   = rd_strobe && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push  = rx_valid && (!full || pop);
        drop  = rx_valid && !push;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        idle_d    = idle_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end

        if (drop && !flush)  overrun_d = 1'b1;
        else if (overrun_clr) overrun_d = 1'b0;

        // Saturating compare also covers timeout_cycles being lowered below idle.
        if (flush || push || pop || empty)  idle_d = '0;
        else if (idle_q >= timeout_cycles)  idle_d = timeout_cycles;
        else                                idle_d = idle_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            idle_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            idle_q    <= idle_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push) mem_q[wr_ptr_q] <= rx_data;
    end

    assign rd_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign fifo_empty = empty;
    assign fifo_full  = full;
    assign overrun    = overrun_q;
    assign irq        = ((irq_threshold != '0) && (count_q >= irq_threshold)) ||
                        ((timeout_cycles != '0) && !empty && (idle_q == timeout_cycles));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: accepted bytes are queued on push and
// compared against rd_data on each pop.
module tb_uart_rx_fifo;

    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic         clk = 1'b0;
    logic         rst, rx_valid, rd_strobe, flush, overrun_clr;
    logic [7:0]   rx_data, rd_data;
    logic [DL2:0] fifo_count, irq_threshold;
    logic         fifo_empty, fifo_full, overrun, irq;
    logic [15:0]  timeout_cycles;

    logic [7:0] q[$];
    logic       movr = 1'b0;
    int         errs = 0;
    int         nchk = 0;

    uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rd_strobe(rd_strobe), .rd_data(rd_data), .fifo_count(fifo_count),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .flush(flush),
        .overrun(overrun), .overrun_clr(overrun_clr),
        .irq_threshold(irq_threshold), .timeout_cycles(timeout_cycles), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"},   32'(fifo_count), 32'(q.size()));
        chk({tag, ".empty"},   32'(fifo_empty), 32'(q.size() == 0));
        chk({tag, ".full"},    32'(fifo_full),  32'(q.size() == DEPTH));
        chk({tag, ".rd_data"}, 32'(rd_data),    (q.size() != 0) ? 32'(q[0]) : 32'h0);
        chk({tag, ".overrun"}, 32'(overrun),    32'(movr));
    endtask

    task automatic push(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        if (q.size() < DEPTH) q.push_back(b);
        else movr = 1'b1;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic pop_chk();
        chk("pop_data", 32'(rd_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
        rd_strobe = 1'b1;
        cyc();
        rd_strobe = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic drain();
        while (q.size() != 0) pop_chk();
    endtask

    task automatic clr_ovr();
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        movr = 1'b0;
    endtask

    task automatic do_flush();
        flush    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        cyc();
        flush    = 1'b0;
        rx_valid = 1'b0;
        q.delete();
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rd_strobe = 1'b0; flush = 1'b0;
        overrun_clr = 1'b0; rx_data = 8'h00; irq_threshold = '0; timeout_cycles = '0;

        // Reset with a coincident rx_valid that must be dropped.
        rx_valid = 1'b1; rx_data = 8'hEE;
        cyc(); cyc();
        rst = 1'b0; rx_valid = 1'b0;
        check_state("reset");
        chk("reset.irq", 32'(irq), 32'h0);

        push(8'h41); push(8'h42); push(8'h43);
        check_state("three");
        pop_chk(); pop_chk(); pop_chk();
        check_state("three_drained");

        // Overflow by one.
        for (int i = 0; i <= DEPTH; i++) push(8'(i));
        check_state("overflow");
        chk("overflow.irq_off", 32'(irq), 32'h0);
        drain();
        check_state("overflow_drained");
        clr_ovr();
        check_state("ovr_clr");

        // Full with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) push(8'h80 + 8'(i));
        chk("pp.head", 32'(rd_data), 32'(q[0]));
        rx_data = 8'hA5; rx_valid = 1'b1; rd_strobe = 1'b1;
        cyc();
        rx_valid = 1'b0; rd_strobe = 1'b0;
        void'(q.pop_front()); q.push_back(8'hA5);
        check_state("full_pushpop");
        drain();
        check_state("full_pp_drained");

        // Pointer wrap across three passes.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 12; i++) push(8'(p * 16 + i + 8'h10));
            check_state("wrap_fill");
            drain();
            check_state("wrap_empty");
        end

        // Level interrupt.
        irq_threshold = 5'd4;
        push(8'h01); push(8'h02); push(8'h03);
        chk("lvl.3", 32'(irq), 32'h0);
        push(8'h04);
        chk("lvl.4", 32'(irq), 32'h1);
        pop_chk();
        chk("lvl.pop", 32'(irq), 32'h0);
        drain();
        irq_threshold = 5'd0;

        // Timeout interrupt: exactly 10 idle cycles after the push.
        timeout_cycles = 16'd10;
        push(8'h5A);
        for (int k = 1; k <= 13; k++) begin
            cyc();
            chk($sformatf("to.k%0d", k), 32'(irq), 32'(k >= 10));
        end
        pop_chk();
        chk("to.pop_irq", 32'(irq), 32'h0);
        check_state("to.popped");

        // Flush keeps a set overrun; flush-time drop does not set it.
        for (int i = 0; i <= DEPTH; i++) push(8'hC0 + 8'(i));
        check_state("pre_flush");
        do_flush();
        check_state("flush_ovr_kept");
        chk("flush.irq", 32'(irq), 32'h0);
        clr_ovr();
        for (int i = 0; i < DEPTH; i++) push(8'hD0 + 8'(i));
        do_flush();
        check_state("flush_full_drop");
        timeout_cycles = 16'd0;

        // Reset mid-operation discards contents.
        push(8'h11); push(8'h22);
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h33;
        cyc();
        rst = 1'b0; rx_valid = 1'b0;
        q.delete(); movr = 1'b0;
        check_state("mid_reset");

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
